// File: rtl/mario_sprite_pkg.sv
// Shared constants and animation frame encoding for the big-Mario sprite,
// used by the sequencer, the frame ROMs and the colour mapper.
package mario_sprite_pkg;

  localparam int          SPRITE_W    = 21;
  localparam int          SPRITE_H    = 41;
  localparam logic [11:0] TRANSPARENT = 12'h808;

  typedef enum logic [2:0] {
    STAND = 3'd0,
    WALK1 = 3'd1,
    WALK2 = 3'd2,
    WALK3 = 3'd3,
    JUMP  = 3'd4
  } anim_frame_t;

endpackage

// File: rtl/mario_anim_fsm.sv
// Animation state machine: frame tick detect, facing and walk-cycle stepping.
// Everything here changes only on a frame tick, so the sprite is stable within a frame.
module mario_anim_fsm
  import mario_sprite_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_clk,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        in_air,
  output anim_frame_t state,
  output logic        flip_h
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic             frame_clk_q;
  logic             tick;
  logic             walking;
  anim_frame_t      state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip_d;

  assign tick    = frame_clk & ~frame_clk_q;
  assign walking = move_left ^ move_right;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_clk_q <= 1'b0;
      state       <= STAND;
      cnt_q       <= '0;
      flip_h      <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      state       <= state_d;
      cnt_q       <= cnt_d;
      flip_h      <= flip_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    flip_d  = flip_h;
    if (tick) begin
      if (move_right && !move_left) flip_d = 1'b0;
      if (move_left && !move_right) flip_d = 1'b1;

      // Airborne beats walking; both directions held counts as standing.
      if (in_air) begin
        state_d = JUMP;
        cnt_d   = '0;
      end else if (!walking) begin
        state_d = STAND;
        cnt_d   = '0;
      end else begin
        case (state)
          STAND, JUMP: begin
            state_d = WALK1;
            cnt_d   = '0;
          end
          default: begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              case (state)
                WALK1:   state_d = WALK2;
                WALK2:   state_d = WALK3;
                default: state_d = WALK1;
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mario_sprite_sequencer.sv
// Big-Mario sprite controller: picks the frame ROM and facing, generates the
// ROM address from the scan position and flags opaque sprite pixels.
module mario_sprite_sequencer
  import mario_sprite_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        in_air,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [11:0] rom_color,
  output logic [9:0]  read_address,
  output logic [2:0]  frame_sel,
  output logic        flip_h,
  output logic        sprite_on
);

  anim_frame_t anim_state;
  logic        in_sprite_q;

  mario_anim_fsm #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_anim_fsm (
    .clk       (Clk),
    .reset     (Reset),
    .frame_clk (frame_clk),
    .move_left (move_left),
    .move_right(move_right),
    .in_air    (in_air),
    .state     (anim_state),
    .flip_h    (flip_h)
  );

  assign frame_sel = anim_state;

  // 11-bit arithmetic so a sprite near the right/bottom edge clips instead of wrapping.
  logic [10:0] dx, dy, mx, my, col, row, col_m;
  logic        in_box;
  logic [9:0]  addr_d;

  assign dx = {1'b0, DrawX};
  assign dy = {1'b0, DrawY};
  assign mx = {1'b0, mario_x};
  assign my = {1'b0, mario_y};

  assign in_box = (dx >= mx) && (dx < mx + 11'(SPRITE_W)) &&
                  (dy >= my) && (dy < my + 11'(SPRITE_H));

  assign col    = dx - mx;
  assign row    = dy - my;
  assign col_m  = flip_h ? (11'(SPRITE_W - 1) - col) : col;
  assign addr_d = 10'(row * 11'(SPRITE_W) + col_m);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      in_sprite_q  <= 1'b0;
    end else begin
      read_address <= in_box ? addr_d : '0;
      in_sprite_q  <= in_box;
    end
  end

  // ROM is asynchronous-read, so rom_color already belongs to read_address.
  assign sprite_on = in_sprite_q && (rom_color != TRANSPARENT);

endmodule

// File: tb/tb_mario_sprite_sequencer.sv
// Bench for mario_sprite_sequencer: directed walk/jump/address cases followed by
// randomized traffic, all checked against a frame-count and geometry model.
module tb_mario_sprite_sequencer;

  localparam int FPS = 6;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, move_left, move_right, in_air;
  logic [9:0]  mario_x, mario_y, DrawX, DrawY;
  logic [11:0] rom_color;
  logic [9:0]  read_address;
  logic [2:0]  frame_sel;
  logic        flip_h, sprite_on;

  int n_tests, n_fail;

  // Model: mode 0 standing, 1 walking, 2 airborne; walk_ticks counts walking ticks.
  int          m_mode, m_walk_ticks;
  bit          m_flip, m_fclk_q, m_insp;
  logic [10:0] exp_q[$];

  mario_sprite_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .move_left(move_left), .move_right(move_right), .in_air(in_air),
    .mario_x(mario_x), .mario_y(mario_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_color(rom_color), .read_address(read_address),
    .frame_sel(frame_sel), .flip_h(flip_h), .sprite_on(sprite_on)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_frame();
    if (m_mode == 2) return 4;
    if (m_mode == 0) return 0;
    return 1 + ((m_walk_ticks - 1) / FPS) % 3;
  endfunction

  function automatic logic [10:0] model_pixel();
    int col, row;
    col = int'(DrawX) - int'(mario_x);
    row = int'(DrawY) - int'(mario_y);
    if (Reset) return 11'd0;
    if (col < 0 || col >= 21 || row < 0 || row >= 41) return 11'd0;
    if (m_flip) col = 20 - col;
    return {1'b1, 10'(row * 21 + col)};
  endfunction

  // One clock: predict from the inputs now on the pins, step, compare.
  task automatic cycle();
    logic [10:0] e;
    bit tick;
    exp_q.push_back(model_pixel());
    if (Reset) begin
      m_mode = 0; m_walk_ticks = 0; m_flip = 0; m_fclk_q = 0;
    end else begin
      tick = frame_clk && !m_fclk_q;
      m_fclk_q = frame_clk;
      if (tick) begin
        if (move_right && !move_left) m_flip = 0;
        if (move_left && !move_right) m_flip = 1;
        if (in_air) begin
          m_mode = 2; m_walk_ticks = 0;
        end else if (move_left == move_right) begin
          m_mode = 0; m_walk_ticks = 0;
        end else begin
          m_mode = 1; m_walk_ticks++;
        end
      end
    end
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    m_insp = e[10];
    check("read_address", 32'(read_address), 32'(e[9:0]));
    check("frame_sel", 32'(frame_sel), 32'(model_frame()));
    check("flip_h", 32'(flip_h), 32'(m_flip));
    check("sprite_on", 32'(sprite_on), 32'(m_insp && rom_color != 12'h808));
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; cycle();
      frame_clk = 1'b0; cycle();
    end
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
    cycle();
  endtask

  task automatic set_rom(input logic [11:0] c);
    rom_color = c;
    #1;
    check("sprite_on_rom", 32'(sprite_on), 32'(m_insp && c != 12'h808));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_mode = 0; m_walk_ticks = 0; m_flip = 0; m_fclk_q = 0; m_insp = 0;
    Reset = 1'b1; frame_clk = 1'b0; move_left = 1'b0; move_right = 1'b0; in_air = 1'b0;
    mario_x = 10'd100; mario_y = 10'd200; DrawX = 10'd0; DrawY = 10'd0;
    rom_color = 12'hF30;

    cycle(); cycle();
    Reset = 1'b0;
    tick_frames(3);

    move_right = 1'b1;
    tick_frames(19);

    in_air = 1'b1;
    cycle(); cycle();
    tick_frames(1);
    check("jump_frame", 32'(frame_sel), 32'd4);
    in_air = 1'b0; move_right = 1'b0;
    tick_frames(1);

    move_right = 1'b1; tick_frames(1); move_right = 1'b0;
    pix(100, 200);
    pix(120, 240);
    check("addr_last", 32'(read_address), 32'd860);
    pix(121, 240);

    move_left = 1'b1; tick_frames(1); move_left = 1'b0;
    pix(100, 201);
    check("addr_flip", 32'(read_address), 32'd41);

    pix(105, 210);
    set_rom(12'h808);
    set_rom(12'hF30);

    move_right = 1'b1; tick_frames(1); move_right = 1'b0;
    mario_x = 10'd1015; mario_y = 10'd0;
    pix(1023, 5);
    check("addr_clip", 32'(read_address), 32'd113);
    pix(0, 5);

    move_right = 1'b1;
    tick_frames(13);
    frame_clk = 1'b1; Reset = 1'b1;
    cycle();
    check("reset_walk3", 32'(frame_sel), 32'd0);
    Reset = 1'b0; frame_clk = 1'b0; move_right = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      frame_clk  = ($urandom_range(0, 2) == 0);
      move_left  = ($urandom_range(0, 2) == 0);
      move_right = ($urandom_range(0, 1) == 0);
      in_air     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) begin
        mario_x = 10'($urandom_range(0, 1023));
        mario_y = 10'($urandom_range(0, 1023));
      end
      DrawX     = 10'(int'(mario_x) + $urandom_range(0, 24) - 2);
      DrawY     = 10'(int'(mario_y) + $urandom_range(0, 44) - 2);
      rom_color = $urandom_range(0, 1) ? 12'h808 : 12'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
